erosion_window_ctrl: RTL and testbench
======================================

// Module: erosion_window_ctrl
// PURPOSE
//  Sequencer for the 3x3 binary-erosion line-buffer datapath. Tracks raster position of the
//  incoming binarized pixel stream, gates the datapath shift enable with a valid/ready
//  handshake, and flags when the 9-tap window is valid/on the border. At end of frame it
//  injects H_ACTIVE+1 zero pixels to flush the final centres out.
// PARAMETERS
//  H_ACTIVE  640  pixels per line
//  V_ACTIVE  480  lines per frame
//  COUNT_W   20   width of linear pixel counters (must hold H_ACTIVE*V_ACTIVE)
// PORTS
//  clock         in   1        system clock, all logic on posedge
//  reset         in   1        asynchronous, active-low; clears all state immediately
//  in_valid      in   1        upstream binarized pixel present
//  in_sof        in   1        qualifies in_valid: first pixel of a frame
//  in_ready      out  1        controller accepts pixel this cycle
//  out_ready     in   1        downstream can take a window this cycle
//  shift_en      out  1        datapath shift strobe (one pixel enters line buffers)
//  flush_inject  out  1        datapath muxes 0 into binarized input while high
//  win_valid     out  1        window taps a8..a0 hold centre (win_row, win_col)
//  win_border    out  1        centre on frame edge; downstream forces eroded bit to 0
//  win_col       out  10       centre column, 0..H_ACTIVE-1
//  win_row       out  9        centre row, 0..V_ACTIVE-1
//  center_count  out  COUNT_W  linear index of centre, 0..H_ACTIVE*V_ACTIVE-1
//  frame_done    out  1        one-cycle pulse after last centre emitted
//  sync_err      out  1        one-cycle pulse: in_sof seen mid-frame
// BEHAVIOUR
//  Reset values: in_ready=0, shift_en=0, flush_inject=0, win_valid=0, win_border=0,
//   win_col=0, win_row=0, center_count=0, frame_done=0, sync_err=0; state=IDLE.
//  accept = in_valid & in_ready. shift_en is combinational: accept (FILL/RUN/IDLE+sof) or
//   (FLUSH & out_ready). Every other output is registered.
//  in_ready = out_ready in IDLE/FILL/RUN; 0 in FLUSH.
//  States:
//   IDLE : accept & in_sof -> FILL, in_count=1. accept without in_sof: pixel dropped, no shift.
//   FILL : each accept increments in_count; win_valid stays 0. On accept making
//          in_count==H_ACTIVE+1 -> RUN (first centre (0,0) now in tap a4).
//   RUN  : each accept -> next cycle win_valid=1, centre advances one pixel (col wraps at
//          H_ACTIVE-1 -> 0, row++). Accept of pixel H_ACTIVE*V_ACTIVE-1 -> FLUSH.
//   FLUSH: while out_ready: shift_en=1, flush_inject=1, emit one centre. After H_ACTIVE+1
//          flush shifts -> frame_done pulses the cycle after the last win_valid, -> IDLE.
//  Latency: win_valid/pos outputs valid exactly 1 cycle after the completing shift_en.
//  win_valid is a one-cycle pulse per shift; low during stalls (out_ready=0).
//  win_border = (win_row==0)|(win_row==V_ACTIVE-1)|(win_col==0)|(win_col==H_ACTIVE-1).
//  center_count = centre linear index; rolls to 0 only on new frame entry.
//  Simultaneous: in_sof with accept in FILL/RUN -> sync_err pulse, window outputs cleared,
//   in_count=1, state FILL (pixel treated as new frame pixel 0). in_sof during FLUSH ignored
//   (in_ready=0); it is accepted once IDLE.
//  Async reset mid-frame: all counters/outputs to reset values; line buffers not cleared,
//   next frame's FILL phase overwrites stale data before any win_valid.
// STRUCTURE
//  Package erosion_pkg: H_ACTIVE/V_ACTIVE defaults, state encoding (IDLE,FILL,RUN,FLUSH).
//  Sub-module erosion_pos_counter (col/row with wrap, enable, sync clear): one instance for
//   input position, one for centre position. FSM + flush counter in this module.
// TESTING (run with H_ACTIVE=8, V_ACTIVE=4 plus one full 640x480 frame)
//  1 Reset: reset=0 mid-stream -> all outputs 0 same cycle; state IDLE after release.
//  2 Full frame, out_ready=1, in_valid=1: first win_valid 1 cycle after 9th shift with
//    (row,col)=(0,0); 32 win_valid pulses total, 9 flush shifts, frame_done once.
//  3 Border: win_border=1 for 20 of 32 centres in 8x4; 0 for centre (1,1)..(2,6).
//  4 Stall: drop out_ready for 5 cycles in RUN -> no shift_en, no win_valid, positions frozen;
//    resume continues at next column with no skipped/duplicated centre.
//  5 Bubbles: in_valid random 50% -> same 32 centres, same order as test 2.
//  6 Mid-frame in_sof at pixel 12 -> sync_err pulse, win_valid stops, refill; first new
//    centre (0,0) 1 cycle after 9th post-sof shift. Pixel w/o sof in IDLE -> no shift_en.

Source files
------------

// File: rtl/erosion_pkg.sv
// Shared defaults, field widths and controller state encoding for the 3x3 erosion sequencer.
package erosion_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COUNT_W_DEF  = 20;
    localparam int COL_W        = 10;
    localparam int ROW_W        = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;
endpackage

// File: rtl/erosion_pos_counter.sv
// Raster column/row counter with wrap, enable and synchronous clear; also exposes the
// position it will move to on the next enable.
module erosion_pos_counter
    import erosion_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_nxt_col,
    output logic [ROW_W-1:0] o_nxt_row
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    always_comb begin
        o_nxt_col = r_col + 1'b1;
        o_nxt_row = r_row;
        if (r_col == COL_LAST) begin
            o_nxt_col = '0;
            o_nxt_row = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            r_col <= o_nxt_col;
            r_row <= o_nxt_row;
        end
    end

    assign o_col = r_col;
    assign o_row = r_row;
endmodule

// File: rtl/erosion_window_ctrl.sv
// Sequencer for the 3x3 binary-erosion line buffers: raster tracking, shift gating,
// window valid/border flags and end-of-frame zero flush.
module erosion_window_ctrl
    import erosion_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    input  logic               out_ready,
    output logic               shift_en,
    output logic               flush_inject,
    output logic               win_valid,
    output logic               win_border,
    output logic [COL_W-1:0]   win_col,
    output logic [ROW_W-1:0]   win_row,
    output logic [COUNT_W-1:0] center_count,
    output logic               frame_done,
    output logic               sync_err
);
    localparam int               FLUSH_W    = $clog2(H_ACTIVE + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_ACTIVE - 1);

    state_t               r_state;
    logic [FLUSH_W-1:0]   r_flush_cnt;
    logic                 r_rdy_en;
    logic                 r_win_valid;
    logic                 r_win_border;
    logic                 r_flush_inject;
    logic                 r_frame_done;
    logic                 r_sync_err;
    logic [COUNT_W-1:0]   r_center_count;

    logic                 w_accept;
    logic                 w_sof_acc;
    logic                 w_pix_acc;
    logic                 w_flush_shift;
    logic                 w_fill_done;
    logic                 w_last_pix;
    logic                 w_flush_emit;
    logic                 w_cen_en;
    logic [COL_W-1:0]     w_unused_in_col;
    logic [ROW_W-1:0]     w_unused_in_row;
    logic [COL_W-1:0]     w_in_nxt_col;
    logic [ROW_W-1:0]     w_in_nxt_row;
    logic [COL_W-1:0]     w_cen_nxt_col;
    logic [ROW_W-1:0]     w_cen_nxt_row;

    function automatic logic is_border(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    endfunction

    // r_rdy_en keeps in_ready low through reset and for the whole flush.
    assign in_ready      = out_ready & r_rdy_en;
    assign w_accept      = in_valid & in_ready;
    assign w_sof_acc     = w_accept & in_sof;
    assign w_pix_acc     = w_accept & ~in_sof & ((r_state == ST_FILL) | (r_state == ST_RUN));
    assign w_flush_shift = (r_state == ST_FLUSH) & out_ready;
    assign shift_en      = w_sof_acc | w_pix_acc | w_flush_shift;

    assign w_fill_done  = w_pix_acc & (r_state == ST_FILL) &
                          (w_in_nxt_row == ROW_W'(1)) & (w_in_nxt_col == '0);
    assign w_last_pix   = w_pix_acc & (r_state == ST_RUN) &
                          (w_in_nxt_row == ROW_LAST) & (w_in_nxt_col == COL_LAST);
    // The final flush shift only pushes the window past the frame; it emits no centre.
    assign w_flush_emit = w_flush_shift & (r_flush_cnt != FLUSH_LAST);
    assign w_cen_en     = (w_pix_acc & (r_state == ST_RUN)) | w_flush_emit;

    erosion_pos_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_in_pos (
        .clock     (clock),
        .reset     (reset),
        .i_clr     (w_sof_acc),
        .i_en      (w_pix_acc),
        .o_col     (w_unused_in_col),
        .o_row     (w_unused_in_row),
        .o_nxt_col (w_in_nxt_col),
        .o_nxt_row (w_in_nxt_row)
    );

    erosion_pos_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_cen_pos (
        .clock     (clock),
        .reset     (reset),
        .i_clr     (w_sof_acc),
        .i_en      (w_cen_en),
        .o_col     (win_col),
        .o_row     (win_row),
        .o_nxt_col (w_cen_nxt_col),
        .o_nxt_row (w_cen_nxt_row)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_flush_cnt    <= '0;
            r_rdy_en       <= 1'b0;
            r_win_valid    <= 1'b0;
            r_win_border   <= 1'b0;
            r_flush_inject <= 1'b0;
            r_frame_done   <= 1'b0;
            r_sync_err     <= 1'b0;
            r_center_count <= '0;
        end else begin
            r_win_valid  <= w_fill_done | w_cen_en;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_rdy_en     <= 1'b1;

            if (w_sof_acc)
                r_win_border <= 1'b0;
            else if (w_fill_done)
                r_win_border <= 1'b1;
            else if (w_cen_en)
                r_win_border <= is_border(w_cen_nxt_row, w_cen_nxt_col);

            if (w_sof_acc)
                r_center_count <= '0;
            else if (w_cen_en)
                r_center_count <= r_center_count + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_sof_acc)
                        r_state <= ST_FILL;
                end
                ST_FILL, ST_RUN: begin
                    if (w_sof_acc) begin
                        r_state    <= ST_FILL;
                        r_sync_err <= 1'b1;
                    end else if (w_fill_done) begin
                        r_state <= ST_RUN;
                    end else if (w_last_pix) begin
                        r_state        <= ST_FLUSH;
                        r_flush_cnt    <= '0;
                        r_flush_inject <= 1'b1;
                        r_rdy_en       <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_rdy_en <= 1'b0;
                    if (w_flush_shift) begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                        if (r_flush_cnt == FLUSH_LAST) begin
                            r_state        <= ST_IDLE;
                            r_frame_done   <= 1'b1;
                            r_flush_inject <= 1'b0;
                            r_rdy_en       <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign win_valid    = r_win_valid;
    assign win_border   = r_win_border;
    assign flush_inject = r_flush_inject;
    assign frame_done   = r_frame_done;
    assign sync_err     = r_sync_err;
    assign center_count = r_center_count;
endmodule

// File: tb/tb_erosion_window_ctrl.sv
// Randomized bench for erosion_window_ctrl on an 8x4 frame against a pixel-count reference model.
module tb_erosion_window_ctrl;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 20;
    localparam int FRAME_BUDGET = 3000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic          flush_inject;
    logic          win_valid;
    logic          win_border;
    logic [9:0]    win_col;
    logic [8:0]    win_row;
    logic [CW-1:0] center_count;
    logic          frame_done;
    logic          sync_err;

    always #5 clock = ~clock;

    erosion_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .COUNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .shift_en     (shift_en),
        .flush_inject (flush_inject),
        .win_valid    (win_valid),
        .win_border   (win_border),
        .win_col      (win_col),
        .win_row      (win_row),
        .center_count (center_count),
        .frame_done   (frame_done),
        .sync_err     (sync_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pixels accepted in the frame and flush shifts done; centre index
    // follows directly from those counts.
    typedef enum {M_IDLE, M_ACT, M_FLUSH} mmode_t;
    mmode_t m_mode;
    int m_n, m_f;
    int e_wv, e_row, e_col, e_cnt, e_bord, e_done, e_serr;
    int s_wv, s_bord, s_fsh, s_done, s_serr;

    function automatic int brd(input int c);
        int row, col;
        row = c / H;
        col = c % H;
        return ((row == 0) || (row == V - 1) || (col == 0) || (col == H - 1)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_n = 0; m_f = 0;
        e_wv = 0; e_row = 0; e_col = 0; e_cnt = 0; e_bord = 0; e_done = 0; e_serr = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_shift_en"}, shift_en, 0);
        chk({pfx, "_flush_inject"}, flush_inject, 0);
        chk({pfx, "_win_valid"}, win_valid, 0);
        chk({pfx, "_win_border"}, win_border, 0);
        chk({pfx, "_win_col"}, win_col, 0);
        chk({pfx, "_win_row"}, win_row, 0);
        chk({pfx, "_center_count"}, center_count, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_sync_err"}, sync_err, 0);
    endtask

    // Called 1 time unit after a rising edge; drives one cycle and checks both sides of it.
    task automatic cycle(input logic v, input logic s, input logic r);
        bit exp_rdy, acc, exp_sh;
        int c;
        in_valid = v; in_sof = s; out_ready = r;
        #1;
        exp_rdy = r && (m_mode != M_FLUSH);
        acc     = v && exp_rdy;
        exp_sh  = (acc && ((m_mode != M_IDLE) || s)) || ((m_mode == M_FLUSH) && r);
        chk("in_ready", in_ready, exp_rdy);
        chk("shift_en", shift_en, exp_sh);
        chk("flush_inject", flush_inject, (m_mode == M_FLUSH));
        if (shift_en && flush_inject) s_fsh++;

        e_wv = 0; e_done = 0; e_serr = 0; c = -1;
        if (acc && s) begin
            if (m_mode != M_IDLE) e_serr = 1;
            m_mode = M_ACT; m_n = 1;
            e_row = 0; e_col = 0; e_cnt = 0; e_bord = 0;
        end else if (acc && (m_mode == M_ACT)) begin
            m_n++;
            if (m_n > H) c = m_n - H - 1;
            if (m_n == H * V) begin m_mode = M_FLUSH; m_f = 0; end
        end else if ((m_mode == M_FLUSH) && r) begin
            m_f++;
            if (m_f <= H) c = H * V - H - 1 + m_f;
            else begin e_done = 1; m_mode = M_IDLE; end
        end
        if (c >= 0) begin
            e_wv = 1; e_row = c / H; e_col = c % H; e_cnt = c; e_bord = brd(c);
        end

        @(posedge clock);
        #1;
        chk("win_valid", win_valid, e_wv);
        chk("win_row", win_row, e_row);
        chk("win_col", win_col, e_col);
        chk("center_count", center_count, e_cnt);
        chk("win_border", win_border, e_bord);
        chk("frame_done", frame_done, e_done);
        chk("sync_err", sync_err, e_serr);
        if (win_valid) s_wv++;
        if (win_valid && win_border) s_bord++;
        if (frame_done) s_done++;
        if (sync_err) s_serr++;
    endtask

    task automatic run_frame(input string tag, input int vp, input int rp, input int sof_at, input int stall_at);
        bit need_sof, pend, stall_done, got_done;
        int stall, cyc;
        logic v, s, r;
        need_sof = 1; pend = (sof_at > 0); stall_done = 0; got_done = 0; stall = 0;
        s_wv = 0; s_bord = 0; s_fsh = 0; s_done = 0; s_serr = 0;
        for (cyc = 0; cyc < FRAME_BUDGET && !got_done; cyc++) begin
            v = ($urandom_range(99) < vp);
            r = ($urandom_range(99) < rp);
            if (stall > 0) begin
                r = 1'b0; stall--;
            end else if (stall_at > 0 && !stall_done && m_mode == M_ACT && m_n == stall_at) begin
                r = 1'b0; stall = 4; stall_done = 1;
            end
            s = 1'b0;
            if (m_mode == M_FLUSH) s = 1'b1;
            else if (need_sof) s = 1'b1;
            else if (pend && m_n == sof_at) s = 1'b1;
            if (s && v && r && m_mode != M_FLUSH) begin
                if (need_sof) need_sof = 0;
                else pend = 0;
            end
            cycle(v, s, r);
            if (e_done != 0) got_done = 1;
        end
        chk({tag, "_frame_end"}, got_done, 1);
        chk({tag, "_wv_pulses"}, s_wv, ((sof_at > H) ? sof_at - H : 0) + H * V);
        chk({tag, "_flush_shifts"}, s_fsh, H + 1);
        chk({tag, "_frame_done_cnt"}, s_done, 1);
        chk({tag, "_sync_err_cnt"}, s_serr, (sof_at > 0) ? 1 : 0);
        if (sof_at == 0) chk({tag, "_border_pulses"}, s_bord, 2 * H + 2 * V - 4);
        in_valid = 0; in_sof = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_outputs("por");
        @(posedge clock); #1;
        reset = 1'b1;
        cycle(0, 0, 0);

        // Pixels without sof while idle must be dropped.
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cycle(1, 0, 1);

        run_frame("full", 100, 100, 0, 0);
        run_frame("stall", 100, 100, 0, 14);
        run_frame("bubble", 50, 100, 0, 0);
        run_frame("bubble_rdy", 50, 70, 0, 0);
        run_frame("sof_mid", 100, 100, 12, 0);

        // Asynchronous reset in the middle of a running frame.
        cycle(1, 1, 1);
        for (int i = 0; i < 14; i++) cycle(1, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();
        cycle(0, 0, 0);
        cycle(1, 0, 1);
        run_frame("after_rst", 60, 80, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
